// File: rtl/sya_loop_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sya_loop_ctrl
// Description : Three-level (row / col / k) loop index generator with a
//               valid/ready tuple stream, abort, and a completion pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module sya_loop_ctrl #(
    parameter int DW = 8
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          CfgVld,
    output logic          CfgRdy,
    input  logic [DW-1:0] CfgNumRow,
    input  logic [DW-1:0] CfgNumCol,
    input  logic [DW-1:0] CfgNumK,
    input  logic          Abort,
    output logic          OutVld,
    input  logic          OutRdy,
    output logic [DW-1:0] OutRow,
    output logic [DW-1:0] OutCol,
    output logic [DW-1:0] OutK,
    output logic          OutLastK,
    output logic          OutLast,
    output logic          Done
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    localparam logic [DW-1:0] c_ZERO = '0;
    localparam logic [DW-1:0] c_ONE  = {{(DW-1){1'b0}}, 1'b1};

    logic [1:0]    r_state;
    logic [DW-1:0] r_num_row;
    logic [DW-1:0] r_num_col;
    logic [DW-1:0] r_num_k;
    logic [DW-1:0] r_row;
    logic [DW-1:0] r_col;
    logic [DW-1:0] r_k;

    logic [DW-1:0] w_cfg_row;
    logic [DW-1:0] w_cfg_col;
    logic [DW-1:0] w_cfg_k;
    logic          w_hs;
    logic          w_k_wrap;
    logic          w_col_wrap;
    logic          w_row_wrap;
    logic          w_last;

    // A zero bound runs its loop once, so bounds are stored already substituted.
    assign w_cfg_row = (CfgNumRow == c_ZERO) ? c_ONE : CfgNumRow;
    assign w_cfg_col = (CfgNumCol == c_ZERO) ? c_ONE : CfgNumCol;
    assign w_cfg_k   = (CfgNumK   == c_ZERO) ? c_ONE : CfgNumK;

    assign w_hs       = OutVld & OutRdy;
    assign w_k_wrap   = (r_k   == (r_num_k   - c_ONE));
    assign w_col_wrap = (r_col == (r_num_col - c_ONE));
    assign w_row_wrap = (r_row == (r_num_row - c_ONE));
    assign w_last     = w_k_wrap & w_col_wrap & w_row_wrap;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state   <= c_ST_IDLE;
            r_num_row <= c_ZERO;
            r_num_col <= c_ZERO;
            r_num_k   <= c_ZERO;
            r_row     <= c_ZERO;
            r_col     <= c_ZERO;
            r_k       <= c_ZERO;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (CfgVld) begin
                        r_num_row <= w_cfg_row;
                        r_num_col <= w_cfg_col;
                        r_num_k   <= w_cfg_k;
                        r_row     <= c_ZERO;
                        r_col     <= c_ZERO;
                        r_k       <= c_ZERO;
                        r_state   <= c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    // Abort wins even over the handshake of the final tuple.
                    if (Abort) begin
                        r_state <= c_ST_IDLE;
                    end else if (w_hs) begin
                        if (w_last) begin
                            r_state <= c_ST_DONE;
                        end else if (w_k_wrap) begin
                            r_k <= c_ZERO;
                            if (w_col_wrap) begin
                                r_col <= c_ZERO;
                                r_row <= r_row + c_ONE;
                            end else begin
                                r_col <= r_col + c_ONE;
                            end
                        end else begin
                            r_k <= r_k + c_ONE;
                        end
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign CfgRdy   = (r_state == c_ST_IDLE);
    assign OutVld   = (r_state == c_ST_RUN);
    assign Done     = (r_state == c_ST_DONE);
    assign OutRow   = r_row;
    assign OutCol   = r_col;
    assign OutK     = r_k;
    assign OutLastK = OutVld & w_k_wrap;
    assign OutLast  = OutVld & w_last;

endmodule
`default_nettype wire

// File: tb/tb_sya_loop_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sya_loop_ctrl
// Description : Self-checking bench for sya_loop_ctrl (vector table plus
//               expected-tuple queue, with hand-written abort/reset cases).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sya_loop_ctrl;

    localparam int DW = 8;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          CfgVld;
    logic          CfgRdy;
    logic [DW-1:0] CfgNumRow;
    logic [DW-1:0] CfgNumCol;
    logic [DW-1:0] CfgNumK;
    logic          Abort;
    logic          OutVld;
    logic          OutRdy;
    logic [DW-1:0] OutRow;
    logic [DW-1:0] OutCol;
    logic [DW-1:0] OutK;
    logic          OutLastK;
    logic          OutLast;
    logic          Done;

    always #5 Clk = ~Clk;

    sya_loop_ctrl #(.DW(DW)) u_dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .CfgVld    (CfgVld),
        .CfgRdy    (CfgRdy),
        .CfgNumRow (CfgNumRow),
        .CfgNumCol (CfgNumCol),
        .CfgNumK   (CfgNumK),
        .Abort     (Abort),
        .OutVld    (OutVld),
        .OutRdy    (OutRdy),
        .OutRow    (OutRow),
        .OutCol    (OutCol),
        .OutK      (OutK),
        .OutLastK  (OutLastK),
        .OutLast   (OutLast),
        .Done      (Done)
    );

    // mode: 0 = OutRdy always 1, 1 = OutRdy toggles (starts low),
    //       2 = CfgVld pulsed with (9,9,9) on the first RUN cycle,
    //       3 = Abort held with the config handshake and during DONE
    typedef struct {
        int nr;
        int nc;
        int nk;
        int mode;
        int exp_cnt;
    } vec_t;

    typedef struct {
        logic [DW-1:0] r;
        logic [DW-1:0] c;
        logic [DW-1:0] k;
        logic          lk;
        logic          l;
    } tup_t;

    tup_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic push_model(input int nr, input int nc, input int nk);
        int er;
        int ec;
        int ek;
        tup_t t;
        er = (nr == 0) ? 1 : nr;
        ec = (nc == 0) ? 1 : nc;
        ek = (nk == 0) ? 1 : nk;
        for (int r = 0; r < er; r++)
            for (int c = 0; c < ec; c++)
                for (int k = 0; k < ek; k++) begin
                    t.r  = DW'(r);
                    t.c  = DW'(c);
                    t.k  = DW'(k);
                    t.lk = (k == ek - 1);
                    t.l  = (r == er - 1) && (c == ec - 1) && (k == ek - 1);
                    exp_q.push_back(t);
                end
    endtask

    task automatic configure(input int nr, input int nc, input int nk, input logic ab);
        int w;
        w = 0;
        while (!CfgRdy && w < 20) begin
            step();
            w++;
        end
        check("cfg_rdy_idle", CfgRdy, 1);
        CfgVld    = 1'b1;
        CfgNumRow = DW'(nr);
        CfgNumCol = DW'(nc);
        CfgNumK   = DW'(nk);
        Abort     = ab;
        step();
        CfgVld    = 1'b0;
        Abort     = 1'b0;
        CfgNumRow = 8'($urandom_range(255));
        CfgNumCol = 8'($urandom_range(255));
        CfgNumK   = 8'($urandom_range(255));
    endtask

    task automatic run_seq(input vec_t v);
        int   hs;
        int   cyc;
        tup_t e;
        push_model(v.nr, v.nc, v.nk);
        configure(v.nr, v.nc, v.nk, (v.mode == 3));
        hs  = 0;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 200) begin
            check("out_vld_run", OutVld, 1);
            if (!OutVld) break;
            if (cyc == 0) begin
                check("done_low_run", Done, 0);
                check("cfg_rdy_run", CfgRdy, 0);
            end
            OutRdy = (v.mode == 1) ? cyc[0] : 1'b1;
            if (v.mode == 2 && cyc == 0) begin
                CfgVld    = 1'b1;
                CfgNumRow = 8'd9;
                CfgNumCol = 8'd9;
                CfgNumK   = 8'd9;
                OutRdy    = 1'b0;
            end
            e = exp_q[0];
            check("out_row",   OutRow,   e.r);
            check("out_col",   OutCol,   e.c);
            check("out_k",     OutK,     e.k);
            check("out_lastk", OutLastK, e.lk);
            check("out_last",  OutLast,  e.l);
            if (OutRdy) begin
                void'(exp_q.pop_front());
                hs++;
            end
            step();
            CfgVld = 1'b0;
            cyc++;
        end
        OutRdy = 1'b0;
        check("tuples_left", exp_q.size(), 0);
        check("handshakes", hs, v.exp_cnt);
        if (v.mode == 3) Abort = 1'b1;
        check("done_pulse", Done, 1);
        check("vld_in_done", OutVld, 0);
        check("lastk_in_done", OutLastK, 0);
        check("last_in_done", OutLast, 0);
        step();
        Abort = 1'b0;
        check("done_cleared", Done, 0);
        check("cfg_rdy_after", CfgRdy, 1);
        exp_q.delete();
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{nr: 2, nc: 2, nk: 3, mode: 0, exp_cnt: 12};
        vecs[1] = '{nr: 1, nc: 1, nk: 4, mode: 1, exp_cnt: 4};
        vecs[2] = '{nr: 0, nc: 3, nk: 0, mode: 0, exp_cnt: 3};
        vecs[3] = '{nr: 1, nc: 1, nk: 2, mode: 2, exp_cnt: 2};
        vecs[4] = '{nr: 3, nc: 1, nk: 2, mode: 3, exp_cnt: 6};
        vecs[5] = '{nr: 1, nc: 2, nk: 0, mode: 1, exp_cnt: 2};

        Rst       = 1'b1;
        CfgVld    = 1'b0;
        CfgNumRow = '0;
        CfgNumCol = '0;
        CfgNumK   = '0;
        Abort     = 1'b0;
        OutRdy    = 1'b0;
        step();
        step();
        Rst = 1'b0;
        check("rst_vld", OutVld, 0);
        check("rst_last", OutLast, 0);
        check("rst_lastk", OutLastK, 0);
        check("rst_done", Done, 0);
        check("rst_cfg_rdy", CfgRdy, 1);
        step();

        for (int i = 0; i < 6; i++) begin
            run_seq(vecs[i]);
        end

        // Abort coinciding with the final handshake of (1,1,2).
        configure(1, 1, 2, 1'b0);
        check("ab_k0", OutK, 0);
        check("ab_last0", OutLast, 0);
        OutRdy = 1'b1;
        step();
        check("ab_k1", OutK, 1);
        check("ab_last1", OutLast, 1);
        Abort = 1'b1;
        step();
        Abort  = 1'b0;
        OutRdy = 1'b0;
        check("ab_vld", OutVld, 0);
        check("ab_done", Done, 0);
        check("ab_cfg_rdy", CfgRdy, 1);
        step();
        check("ab_done_later", Done, 0);

        // Reset mid-run after 5 tuples of (2,2,2), with Cfg/Abort also asserted.
        configure(2, 2, 2, 1'b0);
        OutRdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("rst_run_vld", OutVld, 1);
            step();
        end
        check("rst_run_k", OutK, 1);
        Rst       = 1'b1;
        CfgVld    = 1'b1;
        Abort     = 1'b1;
        step();
        Rst    = 1'b0;
        CfgVld = 1'b0;
        Abort  = 1'b0;
        OutRdy = 1'b0;
        check("mrst_vld", OutVld, 0);
        check("mrst_done", Done, 0);
        check("mrst_cfg_rdy", CfgRdy, 1);
        check("mrst_last", OutLast, 0);
        check("mrst_lastk", OutLastK, 0);
        step();
        check("mrst_done_later", Done, 0);
        check("mrst_vld_later", OutVld, 0);
        run_seq('{nr: 1, nc: 1, nk: 1, mode: 0, exp_cnt: 1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sya_loop_ctrl.md
SYA_LOOP_CTRL -- requirements
Module: sya_loop_ctrl

Interface
REQ-001 SHALL have parameter DW, default 8, width of each loop bound and loop index.
REQ-002 SHALL have port Clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port Rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port CfgVld  input  1  configuration valid.
REQ-005 SHALL have port CfgRdy  output  1  configuration accepted when high with CfgVld.
REQ-006 SHALL have port CfgNumRow  input  DW  row loop bound (outermost).
REQ-007 SHALL have port CfgNumCol  input  DW  column loop bound (middle).
REQ-008 SHALL have port CfgNumK  input  DW  reduction loop bound (innermost).
REQ-009 SHALL have port Abort  input  1  terminate the current sequence.
REQ-010 SHALL have port OutVld  output  1  index tuple valid.
REQ-011 SHALL have port OutRdy  input  1  downstream accepts the tuple.
REQ-012 SHALL have ports OutRow, OutCol, OutK  output  DW each  current loop indices.
REQ-013 SHALL have port OutLastK  output  1  OutK equals its final value.
REQ-014 SHALL have port OutLast  output  1  final tuple of the sequence.
REQ-015 SHALL have port Done  output  1  one-cycle pulse on normal completion.

Function
REQ-016 SHALL implement states IDLE, RUN, DONE.
REQ-017 SHALL drive CfgRdy=1 only in IDLE, and SHALL ignore Cfg* inputs in RUN and DONE.
REQ-018 SHALL, on CfgVld&CfgRdy, latch the three bounds, clear all indices to 0, and enter RUN on the next cycle.
REQ-019 SHALL treat a latched bound of 0 as 1 (one iteration of that loop).
REQ-020 SHALL drive OutVld=1 throughout RUN and OutVld=0 in IDLE and DONE, with the first tuple (0,0,0) valid on the cycle after configuration acceptance.
REQ-021 SHALL advance indices only on OutVld&OutRdy, giving at most one tuple per cycle.
REQ-022 SHALL advance as follows: K increments; at K=NumK-1, K wraps to 0 and Col increments; at Col=NumCol-1 with K wrap, Col wraps to 0 and Row increments.
REQ-023 SHALL hold OutRow/OutCol/OutK/OutLastK/OutLast stable while OutVld=1 and OutRdy=0.
REQ-024 SHALL drive OutLastK=(OutK==NumK-1) and OutLast=(Row,Col,K all at bound-1), both qualified by OutVld.
REQ-025 SHALL enter DONE on the handshake of the OutLast tuple; total handshakes per sequence equal NumRow*NumCol*NumK after zero-to-one substitution.
REQ-026 SHALL, in DONE, assert Done for exactly one cycle and return to IDLE on the next cycle.
REQ-027 SHALL, on Abort in RUN, go to IDLE on the next cycle without Done, with Abort taking priority over a simultaneous handshake (including the OutLast handshake).
REQ-028 SHALL ignore Abort in IDLE and DONE.
REQ-029 SHALL use DW-bit index counters that never exceed bound-1, so no arithmetic overflow occurs for any bound up to 2^DW-1.

Reset
REQ-030 SHALL, while Rst=1 at a clock edge, force state IDLE, indices 0, latched bounds 0, and Done 0.
REQ-031 SHALL present OutVld=0, OutLast=0, OutLastK=0, Done=0, and CfgRdy=1 on the first cycle after Rst deasserts.
REQ-032 SHALL, on Rst asserted mid-RUN, abandon the sequence without a Done pulse and give Rst priority over Abort, Cfg, and handshakes.

Verification
REQ-033 SHALL cover: bounds (2,2,3), OutRdy=1 -> 12 consecutive tuples (0,0,0)..(1,1,2), OutLastK high on every third tuple, OutLast on the 12th, Done one cycle later.
REQ-034 SHALL cover: bounds (1,1,4), OutRdy toggling every cycle -> tuples held while stalled, 4 handshakes total, no index skipped or repeated.
REQ-035 SHALL cover: bounds (0,3,0) -> treated as (1,3,1), 3 tuples (0,0,0),(0,1,0),(0,2,0), OutLastK=1 on each.
REQ-036 SHALL cover: Abort asserted with the OutLast handshake of bounds (1,1,2) -> IDLE next cycle, Done never asserted, CfgRdy=1.
REQ-037 SHALL cover: Rst pulsed after 5 tuples of bounds (2,2,2) -> OutVld=0 and no Done; a new config (1,1,1) then yields exactly one tuple (0,0,0) with OutLast=1.
REQ-038 SHALL cover: CfgVld pulsed with bounds (9,9,9) during RUN of (1,1,2) -> ignored, running sequence completes with 2 tuples.
